// File: rtl/ddp_result_sink_if.sv
// ddp_result_sink_if
// Bundles the result-port handshake (Send_in/Ack_out/PACKET_IN) and the host
// read port (RD_EN/PACKET_OUT/VALID_OUT plus FIFO status) of ddp_result_sink.
//   master : processor + host side (drives Send_in, PACKET_IN, RD_EN)
//   slave  : the result sink (drives Ack_out, PACKET_OUT, VALID_OUT, EMPTY,
//            FULL, COUNT, ACCEPTED)
// Parameters must match the ones given to ddp_result_sink.
interface ddp_result_sink_if #(
   parameter int PACKET_W = 32,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 16
);
   localparam int COUNT_W = $clog2(DEPTH) + 1;

   logic                Send_in;
   logic                Ack_out;
   logic [PACKET_W-1:0] PACKET_IN;
   logic                RD_EN;
   logic [PACKET_W-1:0] PACKET_OUT;
   logic                VALID_OUT;
   logic                EMPTY;
   logic                FULL;
   logic [COUNT_W-1:0]  COUNT;
   logic [CNT_W-1:0]    ACCEPTED;

   modport master (
      output Send_in, PACKET_IN, RD_EN,
      input  Ack_out, PACKET_OUT, VALID_OUT, EMPTY, FULL, COUNT, ACCEPTED
   );

   modport slave (
      input  Send_in, PACKET_IN, RD_EN,
      output Ack_out, PACKET_OUT, VALID_OUT, EMPTY, FULL, COUNT, ACCEPTED
   );
endinterface

// File: rtl/ddp_result_sink.sv
// ddp_result_sink
// Terminates the processor's result-port four-phase Send/Ack handshake, stores
// each accepted packet in a DEPTH-entry synchronous FIFO and serves the host
// through a clocked pop port.
//   CP  : clock, all state on the rising edge
//   MR  : asynchronous active-high reset
//   bus : ddp_result_sink_if.slave
//         Send_in (async request), PACKET_IN (bundled data), Ack_out (registered)
//         RD_EN (pop), PACKET_OUT/VALID_OUT (registered pop result)
//         EMPTY, FULL, COUNT (occupancy), ACCEPTED (packets accepted, wraps)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | Ack_out low; waiting for send_s with room in the FIFO
// ACK   | packet written, Ack_out high; waiting for send_s to drop
module ddp_result_sink #(
   parameter int PACKET_W = 32,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 16
) (
   input logic              CP,
   input logic              MR,
   ddp_result_sink_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACK  = 1'b1;

   logic [0:0]          state;
   logic                send_meta;
   logic                send_s;
   logic                ack;
   logic [PACKET_W-1:0] mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [CNT_W-1:0]    accepted;
   logic [PACKET_W-1:0] packet_out;
   logic                valid_out;
   logic                full;
   logic                empty;
   logic                wr_en;
   logic                rd_en;

   // Status comes from the registered count, so a pop and a push in the same
   // cycle never see each other: a full FIFO defers the push by one cycle and
   // an empty FIFO ignores the pop.
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign wr_en = (state == IDLE) && send_s && !full;
   assign rd_en = bus.RD_EN && !empty;

   // Send_in is asynchronous to CP; PACKET_IN is bundled data and is only
   // sampled once send_s is high, so it needs no synchronizer.
   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         send_meta <= 1'b0;
         send_s    <= 1'b0;
      end else begin
         send_meta <= bus.Send_in;
         send_s    <= send_meta;
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         state <= IDLE;
         ack   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (wr_en) begin
               state <= ACK;
               ack   <= 1'b1;
            end
            ACK: if (!send_s) begin
               state <= IDLE;
               ack   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ack   <= 1'b0;
            end
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge CP) begin
      if (wr_en) mem[wr_ptr] <= bus.PACKET_IN;
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         accepted <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr   <= wr_ptr + 1'b1;
            accepted <= accepted + 1'b1;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         packet_out <= '0;
         valid_out  <= 1'b0;
      end else begin
         valid_out <= rd_en;
         if (rd_en) packet_out <= mem[rd_ptr];
      end
   end

   assign bus.Ack_out    = ack;
   assign bus.PACKET_OUT = packet_out;
   assign bus.VALID_OUT  = valid_out;
   assign bus.EMPTY      = empty;
   assign bus.FULL       = full;
   assign bus.COUNT      = count;
   assign bus.ACCEPTED   = accepted;
endmodule

// File: tb/tb_ddp_result_sink.sv
module tb_ddp_result_sink;
   localparam int PW  = 32;
   localparam int DEP = 8;
   localparam int CW  = 16;

   logic CP;
   logic MR;

   ddp_result_sink_if #(.PACKET_W(PW), .DEPTH(DEP), .CNT_W(CW)) bus ();

   ddp_result_sink #(.PACKET_W(PW), .DEPTH(DEP), .CNT_W(CW)) dut (
      .CP  (CP),
      .MR  (MR),
      .bus (bus)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   int checks = 0;
   int errors = 0;

   // reference model: FIFO contents, accepted total, last popped value
   logic [PW-1:0] q [$];
   int            acc;
   logic [PW-1:0] last_out;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // outputs are sampled and inputs changed on the falling edge
   task automatic cyc();
      @(negedge CP);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"}, 64'(bus.COUNT), 64'(q.size()));
      chk({tag, "_empty"}, 64'(bus.EMPTY), 64'(q.size() == 0));
      chk({tag, "_full"},  64'(bus.FULL),  64'(q.size() == DEP));
      chk({tag, "_accepted"}, 64'(bus.ACCEPTED), 64'(acc % (1 << CW)));
   endtask

   task automatic do_reset();
      MR = 1'b1;
      bus.Send_in   = 1'b0;
      bus.RD_EN     = 1'b0;
      bus.PACKET_IN = '0;
      repeat (3) cyc();
      MR = 1'b0;
      q.delete();
      acc      = 0;
      last_out = '0;
      cyc();
      chk("rst_ack",   64'(bus.Ack_out),    64'd0);
      chk("rst_valid", 64'(bus.VALID_OUT),  64'd0);
      chk("rst_pkt",   64'(bus.PACKET_OUT), 64'd0);
      check_state("rst");
   endtask

   // Ack must fall 2 edges after Send_in falls.
   task automatic wait_release();
      int k;
      bus.Send_in = 1'b0;
      k = 0;
      do begin cyc(); k++; end while (bus.Ack_out && k < 20);
      chk("rel_lat", 64'(k - 1), 64'd2);
   endtask

   // Full handshake into a FIFO that the model says has room:
   // Ack must rise 2 edges after Send_in rises.
   task automatic send_pkt(input logic [PW-1:0] d);
      int k;
      bus.PACKET_IN = d;
      bus.Send_in   = 1'b1;
      k = 0;
      do begin cyc(); k++; end while (!bus.Ack_out && k < 20);
      chk("acc_lat", 64'(k - 1), 64'd2);
      q.push_back(d);
      acc++;
      wait_release();
   endtask

   task automatic read_pkt();
      bus.RD_EN = 1'b1;
      cyc();
      bus.RD_EN = 1'b0;
      if (q.size() > 0) begin
         last_out = q.pop_front();
         chk("rd_valid", 64'(bus.VALID_OUT), 64'd1);
      end else begin
         chk("rd_valid_empty", 64'(bus.VALID_OUT), 64'd0);
      end
      chk("rd_data", 64'(bus.PACKET_OUT), 64'(last_out));
      cyc();
      chk("rd_pulse", 64'(bus.VALID_OUT), 64'd0);
   endtask

   initial begin
      int k;
      logic [PW-1:0] d;
      MR = 1'b1;
      bus.Send_in   = 1'b0;
      bus.RD_EN     = 1'b0;
      bus.PACKET_IN = '0;

      // reset values
      do_reset();

      // single packet
      send_pkt(32'h0000_00A5);
      check_state("single");
      read_pkt();
      check_state("single_rd");

      // fill and backpressure
      do_reset();
      for (int i = 1; i <= 8; i++) send_pkt(PW'(i));
      check_state("fill8");
      bus.PACKET_IN = 32'd9;
      bus.Send_in   = 1'b1;
      repeat (6) cyc();
      chk("bp_ack", 64'(bus.Ack_out), 64'd0);
      check_state("bp");
      bus.RD_EN = 1'b1;
      cyc();
      bus.RD_EN = 1'b0;
      last_out = q.pop_front();
      chk("bp_rd_valid", 64'(bus.VALID_OUT), 64'd1);
      chk("bp_rd_data", 64'(bus.PACKET_OUT), 64'(last_out));
      chk("bp_ack_rd", 64'(bus.Ack_out), 64'd0);
      check_state("bp_rd");
      cyc();
      q.push_back(32'd9);
      acc++;
      chk("bp_ack_late", 64'(bus.Ack_out), 64'd1);
      check_state("bp_acc");
      wait_release();

      // full FIFO, pop in the first cycle send_s is high
      bus.PACKET_IN = 32'd10;
      bus.Send_in   = 1'b1;
      cyc();
      cyc();
      bus.RD_EN = 1'b1;
      cyc();
      bus.RD_EN = 1'b0;
      last_out = q.pop_front();
      chk("sim_full_valid", 64'(bus.VALID_OUT), 64'd1);
      chk("sim_full_data", 64'(bus.PACKET_OUT), 64'(last_out));
      chk("sim_full_ack", 64'(bus.Ack_out), 64'd0);
      check_state("sim_full_rd");
      cyc();
      q.push_back(32'd10);
      acc++;
      chk("sim_full_ack2", 64'(bus.Ack_out), 64'd1);
      check_state("sim_full_wr");
      wait_release();
      while (q.size() > 0) read_pkt();
      check_state("drain");

      // empty FIFO, pop in the write cycle
      do_reset();
      d = $urandom;
      bus.PACKET_IN = d;
      bus.Send_in   = 1'b1;
      cyc();
      cyc();
      bus.RD_EN = 1'b1;
      cyc();
      q.push_back(d);
      acc++;
      chk("sim_empty_valid", 64'(bus.VALID_OUT), 64'd0);
      chk("sim_empty_pkt", 64'(bus.PACKET_OUT), 64'(last_out));
      chk("sim_empty_ack", 64'(bus.Ack_out), 64'd1);
      check_state("sim_empty_wr");
      cyc();
      bus.RD_EN = 1'b0;
      last_out = q.pop_front();
      chk("sim_empty_valid2", 64'(bus.VALID_OUT), 64'd1);
      chk("sim_empty_data", 64'(bus.PACKET_OUT), 64'(last_out));
      check_state("sim_empty_rd");
      wait_release();

      // wrap-around
      for (int i = 0; i < 20; i++) begin
         send_pkt(PW'(32'h100 + i));
         chk("wrap_count_w", 64'(bus.COUNT), 64'd1);
         read_pkt();
         chk("wrap_count_r", 64'(bus.COUNT), 64'd0);
      end
      check_state("wrap");

      // randomized mix of handshakes and pops, including pops when empty
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(2, 0) != 0 && q.size() < DEP) send_pkt($urandom);
         else read_pkt();
         check_state("rand");
      end

      // reset in the middle of a handshake
      do_reset();
      send_pkt($urandom);
      send_pkt($urandom);
      bus.PACKET_IN = 32'hDEAD_0003;
      bus.Send_in   = 1'b1;
      k = 0;
      do begin cyc(); k++; end while (!bus.Ack_out && k < 20);
      q.push_back(32'hDEAD_0003);
      acc++;
      check_state("mid_pre");
      MR = 1'b1;
      #1;
      q.delete();
      acc = 0;
      last_out = '0;
      chk("mid_rst_ack", 64'(bus.Ack_out), 64'd0);
      chk("mid_rst_valid", 64'(bus.VALID_OUT), 64'd0);
      check_state("mid_rst");
      repeat (2) cyc();
      MR = 1'b0;
      bus.PACKET_IN = 32'h0000_5A5A;
      k = 0;
      do begin cyc(); k++; end while (!bus.Ack_out && k < 20);
      chk("mid_new_lat", 64'(k - 1), 64'd2);
      q.push_back(32'h0000_5A5A);
      acc++;
      check_state("mid_new");
      wait_release();
      repeat (4) cyc();
      check_state("mid_single_write");
      read_pkt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddp_result_sink.md
# ddp_result_sink

Output-side collector for the data-driven processor. It terminates the processor's result-port Send/Ack four-phase handshake, buffers each result packet in a synchronous FIFO, and exposes the buffered packets to a clocked host read port. It sits directly downstream of the processor top: its `Send_in`/`Ack_out`/`PACKET_IN` connect to the processor's `Send_out`/`Ack_in`/`PACKET_OUT`.

## Interface
Parameters:
- `PACKET_W`, default 32: packet width; instantiated with the B-stage output packet width.
- `DEPTH`, default 8: number of FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of the accepted-packet counter.

Ports:
- `CP` in 1: the single clock; all state updates on its rising edge.
- `MR` in 1: reset; asynchronous and active-high.
- `Send_in` in 1: request from the processor; asynchronous to `CP`.
- `Ack_out` out 1: acknowledge to the processor; registered.
- `PACKET_IN` in `PACKET_W`: result packet; bundled data, stable while `Send_in` is high.
- `RD_EN` in 1: host pop request.
- `PACKET_OUT` out `PACKET_W`: popped packet; registered.
- `VALID_OUT` out 1: one-cycle strobe marking `PACKET_OUT` as new.
- `EMPTY` out 1: FIFO holds 0 entries.
- `FULL` out 1: FIFO holds `DEPTH` entries.
- `COUNT` out clog2(`DEPTH`)+1: current number of entries.
- `ACCEPTED` out `CNT_W`: total packets accepted since reset; wraps modulo 2^`CNT_W`.

## Operation
- `Send_in` passes through a 2-flop synchronizer; the result is `send_s`. `PACKET_IN` is never synchronized; it is sampled only when `send_s` is high (bundled-data rule).
- The handshake FSM has two states:
  - **IDLE**: `Ack_out`=0.
    - If `send_s`=1 and `FULL`=0: write `PACKET_IN` at the write pointer, increment the write pointer (wraps at `DEPTH`), increment `ACCEPTED`, set `Ack_out`=1, and go to ACK.
    - If `send_s`=1 and `FULL`=1: stay in IDLE with `Ack_out`=0. This is backpressure; the processor holds `Send_in` high.
  - **ACK**: `Ack_out`=1.
    - If `send_s`=0: set `Ack_out`=0 and go to IDLE.
    - Otherwise hold.
- Exactly one write happens per four-phase cycle. `send_s` staying high in ACK never causes a second write.
- Read side:
  - `RD_EN`=1 with `EMPTY`=0: `PACKET_OUT` is loaded with the head entry, the read pointer increments (wraps), and `VALID_OUT`=1 for one cycle.
  - `RD_EN`=1 with `EMPTY`=1: ignored. `PACKET_OUT` holds its value and `VALID_OUT`=0.
- `COUNT` changes by +1 for a write only, -1 for a read only, and 0 when both happen in the same cycle.
- `FULL` and `EMPTY` are decoded from the registered `COUNT`:
  - With `FULL`=1 and a read in cycle n, the write is not accepted in cycle n; it is accepted in n+1 if `send_s` is still 1.
  - With `EMPTY`=1 and a write in cycle n, a read in cycle n is ignored. The entry is readable from n+1.
- Reset (`MR`=1, asynchronous, at any time including mid-handshake):
  - FSM goes to IDLE; pointers, `COUNT`, `ACCEPTED`, `PACKET_OUT` and the synchronizer flops go to 0.
  - Outputs: `Ack_out`=0, `VALID_OUT`=0, `EMPTY`=1, `FULL`=0.
  - FIFO storage is not cleared.
  - After `MR` is released, a `Send_in` that is still high is treated as a new request.

## Timing
- Accept latency: `Send_in` rises before edge n → `send_s`=1 after edge n+1 → write and `Ack_out`=1 after edge n+2.
- Release latency: `Send_in` falls before edge m → `Ack_out`=0 after edge m+2.
- Minimum full handshake: 4 `CP` cycles from request to release, plus the processor's own delay.
- Read latency: `RD_EN` sampled at edge k → `PACKET_OUT`/`VALID_OUT` valid after edge k.
- Sustained throughput: one packet per handshake on the write side; one packet per cycle on the read side.

## Test plan
- Reset values: assert `MR` for 3 cycles, then release → `Ack_out`=0, `EMPTY`=1, `COUNT`=0, `ACCEPTED`=0, `PACKET_OUT`=0.
- Single packet: handshake with `PACKET_IN`=0x0000_00A5 → `Ack_out` rises 2 cycles after `Send_in` and falls 2 cycles after `Send_in` falls; `COUNT`=1. Then `RD_EN`=1 → `PACKET_OUT`=0x0000_00A5, `VALID_OUT` pulses once, `EMPTY`=1.
- Fill and backpressure: 9 handshakes with values 1..9 and no reads → `FULL`=1 after the 8th, and the 9th request sees `Ack_out`=0. One read returns 1, then the 9th is acknowledged; `ACCEPTED`=9.
- Wrap-around: 20 alternating write/read pairs with values 0x100..0x113 → data returns in order, `COUNT` never exceeds 1, and the pointers wrap with no loss.
- Simultaneous events:
  - With `FULL`=1, assert `RD_EN` in the cycle `send_s` is high → the write is delayed one cycle and `COUNT` stays 8 overall.
  - With `EMPTY`=1, a read in the write cycle is ignored (`VALID_OUT`=0).
- Reset mid-handshake: assert `MR` while in ACK with `COUNT`=3 → `Ack_out`=0 and `COUNT`=0 immediately. Keep `Send_in` high through release → one new write, `ACCEPTED`=1.
